display_result_ctrl: RTL and testbench



---
 rtl/display_result_ctrl_if.sv | 19 +
 rtl/display_result_ctrl.sv | 86 ++++++++
 tb/tb_display_result_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/display_result_ctrl_if.sv
// display_result_ctrl_if: result handshake plus digit outputs between producer/driver side and the display controller
interface display_result_ctrl_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             clear;
  logic [3:0]       d3, d2, d1, d0;
  logic             is_negative;
  logic             overflow;
  logic             done;
  modport master (
    output in_valid, in_data, clear,
    input  in_ready, d3, d2, d1, d0, is_negative, overflow, done
  );
  modport slave (
    input  in_valid, in_data, clear,
    output in_ready, d3, d2, d1, d0, is_negative, overflow, done
  );
endinterface

// File: rtl/display_result_ctrl.sv
// display_result_ctrl: clamps a signed result, converts it to BCD bit-serially and registers blanked digits
module display_result_ctrl #(
  parameter int WIDTH    = 16,
  parameter bit LZ_BLANK = 1'b1
) (
  input logic                   clk,
  input logic                   reset_n,
  display_result_ctrl_if.slave  bus
);
  localparam int MW = WIDTH > 14 ? WIDTH : 14;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [3:0] BLANK   = 4'd15;
  localparam logic [3:0] LZ_CODE = LZ_BLANK ? 4'd15 : 4'd0;
  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;
  state_t           state;
  logic [WIDTH-1:0] mag, abs_v;
  logic [16:0]      bcd, bcd_adj;
  logic [CW-1:0]    cnt;
  logic             sign, ovf_r, z3, z2, z1;
  logic [MW-1:0]    abs_x, lim_x;
  assign abs_v = bus.in_data[WIDTH-1] ? -bus.in_data : bus.in_data;
  assign abs_x = MW'(abs_v);
  assign lim_x = bus.in_data[WIDTH-1] ? MW'(999) : MW'(9999);
  assign bus.in_ready = (state == IDLE) && !bus.clear;
  assign z3 = bcd[15:12] == 4'd0;
  assign z2 = z3 && bcd[11:8] == 4'd0;
  assign z1 = z2 && bcd[7:4] == 4'd0;
  // add-3 correction on every BCD nibble ahead of the next shift
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++)
      bcd_adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  // sequencer: accept/clamp, shift-add-3 for WIDTH cycles, then register digits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      mag             <= '0;
      bcd             <= '0;
      cnt             <= '0;
      sign            <= 1'b0;
      ovf_r           <= 1'b0;
      bus.d3          <= LZ_CODE;
      bus.d2          <= LZ_CODE;
      bus.d1          <= LZ_CODE;
      bus.d0          <= 4'd0;
      bus.is_negative <= 1'b0;
      bus.overflow    <= 1'b0;
      bus.done        <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.clear) begin
            {bus.d3, bus.d2, bus.d1, bus.d0} <= {4{BLANK}};
            bus.is_negative <= 1'b0;
            bus.overflow    <= 1'b0;
          end else if (bus.in_valid) begin
            sign  <= bus.in_data[WIDTH-1];
            ovf_r <= abs_x > lim_x;
            mag   <= abs_x > lim_x ? WIDTH'(lim_x) : abs_v;
            bcd   <= '0;
            cnt   <= '0;
            state <= CONV;
          end
        end
        CONV: begin
          {bcd, mag} <= {bcd_adj[15:0], mag, 1'b0};
          cnt        <= cnt + 1'b1;
          state      <= cnt == CW'(WIDTH - 1) ? LOAD : CONV;
        end
        LOAD: begin
          bus.d3          <= LZ_BLANK && (z3 || sign) ? BLANK : bcd[15:12];
          bus.d2          <= LZ_BLANK && z2 ? BLANK : bcd[11:8];
          bus.d1          <= LZ_BLANK && z1 ? BLANK : bcd[7:4];
          bus.d0          <= bcd[3:0];
          bus.is_negative <= sign;
          bus.overflow    <= ovf_r;
          bus.done        <= 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_display_result_ctrl.sv
// tb_display_result_ctrl: directed scoreboard bench for the signed-result display controller
module tb_display_result_ctrl;
  typedef struct {
    logic [3:0] d3, d2, d1, d0;
    logic       neg, ovf;
  } exp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int total = 0;
  int bad = 0;
  exp_t q[$];
  display_result_ctrl_if #(.WIDTH(16)) bus1();
  display_result_ctrl_if #(.WIDTH(16)) bus2();
  display_result_ctrl #(.WIDTH(16), .LZ_BLANK(1'b1)) dut  (.clk(clk), .reset_n(reset_n), .bus(bus1));
  display_result_ctrl #(.WIDTH(16), .LZ_BLANK(1'b0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus2));
  always #5 clk = ~clk;
  function automatic exp_t model(int v, bit lz);
    exp_t e;
    int m;
    int dg[4];
    e.neg = v < 0;
    m = v < 0 ? -v : v;
    e.ovf = m > (e.neg ? 999 : 9999);
    if (e.ovf) m = e.neg ? 999 : 9999;
    for (int i = 0; i < 4; i++) begin
      dg[i] = m % 10;
      m = m / 10;
    end
    e.d0 = 4'(dg[0]);
    e.d1 = (lz && dg[3] == 0 && dg[2] == 0 && dg[1] == 0) ? 4'd15 : 4'(dg[1]);
    e.d2 = (lz && dg[3] == 0 && dg[2] == 0) ? 4'd15 : 4'(dg[2]);
    e.d3 = (lz && (dg[3] == 0 || e.neg)) ? 4'd15 : 4'(dg[3]);
    return e;
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic check_out(string tag, exp_t e);
    chk({tag, "_d3"}, 32'(bus1.d3), 32'(e.d3));
    chk({tag, "_d2"}, 32'(bus1.d2), 32'(e.d2));
    chk({tag, "_d1"}, 32'(bus1.d1), 32'(e.d1));
    chk({tag, "_d0"}, 32'(bus1.d0), 32'(e.d0));
    chk({tag, "_neg"}, 32'(bus1.is_negative), 32'(e.neg));
    chk({tag, "_ovf"}, 32'(bus1.overflow), 32'(e.ovf));
  endtask
  task automatic check_reset(string tag);
    chk({tag, "_ready"}, 32'(bus1.in_ready), 1);
    chk({tag, "_done"}, 32'(bus1.done), 0);
    chk({tag, "_d3"}, 32'(bus1.d3), 15);
    chk({tag, "_d2"}, 32'(bus1.d2), 15);
    chk({tag, "_d1"}, 32'(bus1.d1), 15);
    chk({tag, "_d0"}, 32'(bus1.d0), 0);
    chk({tag, "_neg"}, 32'(bus1.is_negative), 0);
    chk({tag, "_ovf"}, 32'(bus1.overflow), 0);
  endtask
  task automatic accept(string tag, int v);
    bus1.in_data = 16'(v);
    bus1.in_valid = 1'b1;
    #1;
    chk({tag, "_ready_before"}, 32'(bus1.in_ready), 1);
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    q.push_back(model(v, 1'b1));
  endtask
  task automatic wait_done(string tag);
    int n = 0;
    int rdy = 0;
    bit seen = 1'b0;
    repeat (40) if (!seen) begin
      @(posedge clk);
      #1;
      n++;
      if (bus1.done) seen = 1'b1;
      else if (bus1.in_ready) rdy++;
    end
    chk({tag, "_done_seen"}, 32'(seen), 1);
    chk({tag, "_latency"}, 32'(n), 17);
    chk({tag, "_ready_low"}, 32'(rdy), 0);
    if (seen && q.size() > 0) check_out(tag, q.pop_front());
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, 32'(bus1.done), 0);
  endtask
  initial begin
    int n;
    int x;
    int pulses;
    bit prev;
    bit seen1;
    exp_t e;
    bus1.in_valid = 1'b0;
    bus1.in_data = '0;
    bus1.clear = 1'b0;
    bus2.in_valid = 1'b0;
    bus2.in_data = '0;
    bus2.clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    chk("reset_lz0_d3", 32'(bus2.d3), 0);
    chk("reset_lz0_d1", 32'(bus2.d1), 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    accept("v1234", 1234);
    wait_done("v1234");
    accept("vm42", -42);
    wait_done("vm42");
    accept("v7", 7);
    wait_done("v7");
    accept("v12345", 12345);
    wait_done("v12345");
    accept("vm32768", -32768);
    wait_done("vm32768");
    accept("v0", 0);
    wait_done("v0");
    bus1.in_data = 16'(5);
    bus1.in_valid = 1'b1;
    @(posedge clk);
    #1;
    q.push_back(model(5, 1'b1));
    bus1.in_data = 16'(-5);
    n = 0;
    x = 0;
    seen1 = 1'b0;
    prev = bus1.in_ready;
    repeat (40) if (x == 0) begin
      @(posedge clk);
      #1;
      n++;
      if (bus1.done) begin
        seen1 = 1'b1;
        chk("b2b_first_latency", 32'(n), 17);
        if (q.size() > 0) check_out("b2b_first", q.pop_front());
      end
      if (prev) x = n;
      prev = bus1.in_ready;
    end
    bus1.in_valid = 1'b0;
    q.push_back(model(-5, 1'b1));
    chk("b2b_first_done_seen", 32'(seen1), 1);
    chk("b2b_second_xfer_gap", 32'(x), 18);
    wait_done("b2b_second");
    bus1.clear = 1'b1;
    bus1.in_valid = 1'b1;
    bus1.in_data = 16'(77);
    #1;
    chk("clear_ready", 32'(bus1.in_ready), 0);
    @(posedge clk);
    #1;
    e = '{d3: 4'd15, d2: 4'd15, d1: 4'd15, d0: 4'd15, neg: 1'b0, ovf: 1'b0};
    check_out("clear", e);
    chk("clear_done", 32'(bus1.done), 0);
    bus1.clear = 1'b0;
    bus1.in_valid = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus1.done) pulses++;
    end
    chk("clear_no_xfer_pulses", 32'(pulses), 0);
    chk("clear_no_xfer_ready", 32'(bus1.in_ready), 1);
    accept("v999", 999);
    repeat (8) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset("midreset");
    q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    pulses = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (bus1.done) pulses++;
    end
    chk("midreset_no_done", 32'(pulses), 0);
    accept("v321", 321);
    wait_done("v321");
    bus2.in_data = 16'(56);
    bus2.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus2.in_valid = 1'b0;
    e = model(56, 1'b0);
    seen1 = 1'b0;
    repeat (40) if (!seen1) begin
      @(posedge clk);
      #1;
      if (bus2.done) seen1 = 1'b1;
    end
    chk("lz0_done_seen", 32'(seen1), 1);
    chk("lz0_d3", 32'(bus2.d3), 32'(e.d3));
    chk("lz0_d2", 32'(bus2.d2), 32'(e.d2));
    chk("lz0_d1", 32'(bus2.d1), 32'(e.d1));
    chk("lz0_d0", 32'(bus2.d0), 32'(e.d0));
    chk("lz0_neg", 32'(bus2.is_negative), 0);
    chk("scoreboard_empty", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
